// File: rtl/debugger_pkg.sv
// -----------------------------------------------------------------------------
// debugger_pkg
// Constants shared by the debugger command encoder (host side) and the AFTAB
// debugger command decoder (datapath side): command-word bit positions, the
// register-number field, the encoder state encoding and a command-word builder.
// -----------------------------------------------------------------------------
package debugger_pkg;

   localparam int unsigned DBG_WRITE_BIT    = 16;
   localparam int unsigned DBG_REGISTER_BIT = 17;
   localparam int unsigned DBG_MEMORY_BIT   = 25;
   localparam int unsigned DBG_REGNUM_MSB   = 4;
   localparam int unsigned DBG_REGNUM_LSB   = 0;
   localparam int unsigned DBG_REGNUM_W     = DBG_REGNUM_MSB - DBG_REGNUM_LSB + 1;
   localparam int unsigned DBG_CMD_W        = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND_ADDR = 3'd1,
      ST_SEND_DATA = 3'd2,
      ST_SEND_CMD  = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_CLEAR     = 3'd5,
      ST_RSP       = 3'd6
   } dbg_state_e;

   // Register number is only meaningful for register accesses; memory
   // commands carry 0 in that field.
   function automatic logic [DBG_CMD_W-1:0] dbg_encode_cmd(
      input logic                    is_write,
      input logic                    is_memory,
      input logic [DBG_REGNUM_W-1:0] regnum
   );
      logic [DBG_CMD_W-1:0] cmd;
      cmd                   = '0;
      cmd[DBG_WRITE_BIT]    = is_write;
      cmd[DBG_REGISTER_BIT] = ~is_memory;
      cmd[DBG_MEMORY_BIT]   = is_memory;
      if (!is_memory)
         cmd[DBG_REGNUM_MSB:DBG_REGNUM_LSB] = regnum;
      return cmd;
   endfunction

endpackage

// File: rtl/aftab_register.sv
// -----------------------------------------------------------------------------
// aftab_register
// Generic AFTAB load/clear register.
//   clk, rst : clock, asynchronous active-high reset
//   zero     : synchronous clear (takes priority over load)
//   load     : load inReg
//   inReg    : data in  [size-1:0]
//   outReg   : data out [size-1:0]
// -----------------------------------------------------------------------------
module aftab_register #(
   parameter int unsigned size = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            zero,
   input  logic            load,
   input  logic [size-1:0] inReg,
   output logic [size-1:0] outReg
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         outReg <= '0;
      else if (zero)
         outReg <= '0;
      else if (load)
         outReg <= inReg;
   end

endmodule

// File: rtl/debugger_command_encoder.sv
// -----------------------------------------------------------------------------
// debugger_command_encoder
// Host-side sequencer turning one debugger request into the argument/command
// word sequence and load strobes of the AFTAB debugger command decoder, then
// waiting for completion, clearing the command register and responding.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid / req_ready          host request handshake (ready only in IDLE)
//   req_is_write, req_is_memory    request kind
//   req_register_number [4:0]      register target (ignored for memory)
//   req_address, req_data [size]   memory address, write data
//   debugger_done                  one-cycle completion pulse from datapath
//   debugger_read_data [size]      read result, valid with debugger_done
//   debugger_port [size]           word driven to decoder registers
//   load_debugger_command*         decoder register load strobes
//   rsp_valid / rsp_ready          host response handshake
//   rsp_data [size], rsp_error     read data (0 for writes), timeout flag
//
// Optional feature macro: DEBUGGER_TIMEOUT_EN -- WAIT_DONE watchdog that aborts
// after timeout_cycles cycles and reports rsp_error. Undefined: waits forever,
// rsp_error is tied low.
// -----------------------------------------------------------------------------
module debugger_command_encoder
   import debugger_pkg::*;
#(
   parameter int unsigned size           = 32,
   parameter int unsigned timeout_cycles = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_is_write,
   input  logic                    req_is_memory,
   input  logic [DBG_REGNUM_W-1:0] req_register_number,
   input  logic [size-1:0]         req_address,
   input  logic [size-1:0]         req_data,
   input  logic                    debugger_done,
   input  logic [size-1:0]         debugger_read_data,
   output logic [size-1:0]         debugger_port,
   output logic                    load_debugger_command,
   output logic                    load_debugger_command_data_argument,
   output logic                    load_debugger_command_address_argument,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [size-1:0]         rsp_data,
   output logic                    rsp_error
);

   dbg_state_e              state_q, state_d;
   logic                    is_write_q, is_memory_q;
   logic [DBG_REGNUM_W-1:0] regnum_q;
   logic [size-1:0]         addr_q, data_q;
   logic                    accept;
   logic                    done_hit;
   logic                    expire;

   assign accept   = req_valid & (state_q == ST_IDLE);
   assign done_hit = debugger_done & (state_q == ST_WAIT_DONE);

   // ---------------------------------------------------------------- request latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_write_q  <= 1'b0;
         is_memory_q <= 1'b0;
         regnum_q    <= '0;
         addr_q      <= '0;
         data_q      <= '0;
      end else if (accept) begin
         is_write_q  <= req_is_write;
         is_memory_q <= req_is_memory;
         regnum_q    <= req_register_number;
         addr_q      <= req_address;
         data_q      <= req_data;
      end
   end

   // ---------------------------------------------------------------- watchdog
`ifdef DEBUGGER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(timeout_cycles + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // Expiry on the timeout_cycles-th WAIT_DONE cycle; a coincident done wins.
   assign expire = (state_q == ST_WAIT_DONE) && (cnt_q == CNT_W'(timeout_cycles - 1))
                   && !debugger_done;

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (state_q == ST_SEND_CMD)
         cnt_d = '0;
      else if (state_q == ST_WAIT_DONE)
         cnt_d = cnt_q + 1'b1;
      if (accept)
         err_d = 1'b0;
      else if (expire)
         err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign rsp_error = err_q;
`else
   assign expire    = 1'b0;
   assign rsp_error = 1'b0;
`endif

   // ---------------------------------------------------------------- read capture
   // Cleared on acceptance so writes and timeouts respond with 0.
   aftab_register #(
      .size (size)
   ) u_rsp_data (
      .clk    (clk),
      .rst    (rst),
      .zero   (accept),
      .load   (done_hit),
      .inReg  (is_write_q ? '0 : debugger_read_data),
      .outReg (rsp_data)
   );

   // ---------------------------------------------------------------- FSM state
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // ---------------------------------------------------------------- FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (req_is_memory)     state_d = ST_SEND_ADDR;
               else if (req_is_write) state_d = ST_SEND_DATA;
               else                   state_d = ST_SEND_CMD;
            end
         end
         ST_SEND_ADDR: state_d = is_write_q ? ST_SEND_DATA : ST_SEND_CMD;
         ST_SEND_DATA: state_d = ST_SEND_CMD;
         ST_SEND_CMD:  state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: if (debugger_done || expire) state_d = ST_CLEAR;
         ST_CLEAR:     state_d = ST_RSP;
         ST_RSP:       if (rsp_ready) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- FSM outputs
   always_comb begin
      debugger_port                          = '0;
      load_debugger_command                  = 1'b0;
      load_debugger_command_data_argument    = 1'b0;
      load_debugger_command_address_argument = 1'b0;
      req_ready                              = 1'b0;
      rsp_valid                              = 1'b0;
      unique case (state_q)
         ST_IDLE: req_ready = 1'b1;
         ST_SEND_ADDR: begin
            debugger_port                          = addr_q;
            load_debugger_command_address_argument = 1'b1;
         end
         ST_SEND_DATA: begin
            debugger_port                       = data_q;
            load_debugger_command_data_argument = 1'b1;
         end
         ST_SEND_CMD: begin
            debugger_port         = size'(dbg_encode_cmd(is_write_q, is_memory_q, regnum_q));
            load_debugger_command = 1'b1;
         end
         // Loading an all-zero command drops every decoder request line.
         ST_CLEAR: load_debugger_command = 1'b1;
         ST_RSP:   rsp_valid = 1'b1;
         default: ;
      endcase
   end

endmodule
